// File: rtl/led_ser_pkg.sv
// Shared types and constants for the LED shift-chain receiver.
// Holds the FSM state encoding, synchroniser depth and bit-count width.
package led_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 6;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-FF synchroniser with one alignment register and rising-edge flag.
// Ports: clk_i, rst_ni (sync, active-low), d_i async in, q_o level or edge.
module sync_edge_det
  import led_ser_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   edge_q;

  // dly_q and edge_q sit at the same depth so a level taken from dly_q
  // lines up with the edge flag of a sibling instance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
    end
  end

  assign q_o = EDGE ? edge_q : dly_q;

endmodule

// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the LED shift chain (CLK/CLR/EN/D0).
// Ports: clk, rst, s_* line inputs; data_out, data_valid, frame_err, busy, bit_cnt.
module led_s2p_rx
  import led_ser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int INVERT    = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_clk,
  input  logic             s_d0,
  input  logic             s_en,
  input  logic             s_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic edge_s;
  logic d_s;
  logic en_s;
  logic clr_s;

  sync_edge_det #(.EDGE(1'b1)) u_clk (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (s_clk),
    .q_o   (edge_s)
  );

  sync_edge_det #(.EDGE(1'b0)) u_d0 (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (s_d0),
    .q_o   (d_s)
  );

  sync_edge_det #(.EDGE(1'b0)) u_en (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (s_en),
    .q_o   (en_s)
  );

  sync_edge_det #(.EDGE(1'b0)) u_clr (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (s_clr),
    .q_o   (clr_s)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             pend_q, pend_d;
  logic             pbit_q, pbit_d;

  logic             bit_in;
  logic             ev;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pend_q  <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      pbit_q  <= pbit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pend_d   = pend_q;
    pbit_d   = pbit_q;
    // An edge parked during DONE is replayed in IDLE with its own bit.
    ev       = edge_s | pend_q;
    bit_in   = pend_q ? pbit_q : d_s;
    cnt_inc  = cnt_q + 1'b1;
    last_bit = (cnt_inc == CNT_W'(WIDTH));
    if (MSB_FIRST != 0) begin
      shifted = {shreg_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shreg_q[WIDTH-1:1]};
    end

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (ev && en_s) begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          tmo_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_s) begin
          shreg_d = shifted;
          cnt_d   = cnt_inc;
          tmo_d   = '0;
          // The edge is counted before a coincident EN fall is judged.
          if (last_bit) begin
            dout_d  = (INVERT != 0) ? ~shifted : shifted;
            state_d = DONE;
          end else if (!en_s) begin
            state_d = ERR;
          end
        end else if (!en_s) begin
          state_d = ERR;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = IDLE;
        if (edge_s) begin
          pend_d = 1'b1;
          pbit_d = d_s;
        end
      end
      ERR: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!clr_s) begin
      state_d = IDLE;
      shreg_d = '0;
      dout_d  = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      pend_d  = 1'b0;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = (state_q == DONE);
  assign frame_err  = (state_q == ERR);
  assign busy       = (state_q == SHIFT);
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Scoreboard bench for led_s2p_rx: two instances (MSB/inverted, LSB/plain)
// share one serial line; a negedge monitor pops expected words and errors.
module tb_led_s2p_rx;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst;
  logic s_clk, s_d0, s_en, s_clr;

  logic [15:0] do_a, do_b;
  logic        dv_a, dv_b, fe_a, fe_b, bz_a, bz_b;
  logic [5:0]  bc_a, bc_b;

  always #5 clk = ~clk;

  led_s2p_rx #(
    .WIDTH(16), .MSB_FIRST(1), .INVERT(1), .TIMEOUT(TMO)
  ) dut_a (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_d0(s_d0),
    .s_en(s_en), .s_clr(s_clr), .data_out(do_a),
    .data_valid(dv_a), .frame_err(fe_a), .busy(bz_a),
    .bit_cnt(bc_a)
  );

  led_s2p_rx #(
    .WIDTH(16), .MSB_FIRST(0), .INVERT(0), .TIMEOUT(TMO)
  ) dut_b (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_d0(s_d0),
    .s_en(s_en), .s_clr(s_clr), .data_out(do_b),
    .data_valid(dv_b), .frame_err(fe_b), .busy(bz_b),
    .bit_cnt(bc_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int t5 = 0;
  int ea = 0;
  int eb = 0;
  bit lat_arm = 0;
  bit tmo_ph = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;
  logic [5:0]  prev_bc = '0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected pulse expected none", nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (dv_a || fe_a) check("excl_a", {31'd0, dv_a & fe_a}, 0);
      if (dv_b || fe_b) check("excl_b", {31'd0, dv_b & fe_b}, 0);
      if (dv_a) begin
        if (qa.size() == 0) unexp("valid_a");
        else begin
          last_a = qa.pop_front();
          check("data_a", {16'd0, do_a}, {16'd0, last_a});
        end
      end
      if (dv_b) begin
        if (qb.size() == 0) unexp("valid_b");
        else begin
          last_b = qb.pop_front();
          check("data_b", {16'd0, do_b}, {16'd0, last_b});
          if (lat_arm) begin
            check("latency", cyc - rise_cyc, 4);
            lat_arm = 0;
          end
        end
      end
      if (fe_a) begin
        if (ea == 0) unexp("err_a");
        else begin
          ea--;
          check("hold_a", {16'd0, do_a}, {16'd0, last_a});
          if (tmo_ph) check("tmo_lat", cyc - t5, TMO);
        end
      end
      if (fe_b) begin
        if (eb == 0) unexp("err_b");
        else begin
          eb--;
          check("hold_b", {16'd0, do_b}, {16'd0, last_b});
        end
      end
      if (bc_a == 6'd5 && prev_bc != 6'd5) t5 = cyc;
      prev_bc = bc_a;
    end
  end

  task automatic send_frame(input logic [15:0] w, input bit lsb,
                            input int nb, input bit drop);
    s_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      s_d0  = lsb ? w[i] : w[15-i];
      s_clk = 1'b0;
      repeat (4) @(negedge clk);
      s_clk    = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
    end
    s_clk = 1'b0;
    if (drop) begin
      repeat (2) @(negedge clk);
      s_en = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  initial begin
    rst = 1'b0; s_clk = 1'b0; s_d0 = 1'b0; s_en = 1'b0; s_clr = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", {16'd0, do_a}, 0);
    check("rst_valid", {31'd0, dv_a}, 0);
    check("rst_err", {31'd0, fe_a}, 0);
    check("rst_busy", {31'd0, bz_a}, 0);
    check("rst_cnt", {26'd0, bc_a}, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // MSB-first decode
    push(16'hA5C3, 16'h3C5A);
    send_frame(16'h5A3C, 1'b0, 16, 1'b1);
    check("cnt_idle", {26'd0, bc_a}, 0);

    // LSB-first with latency
    push(16'h7FFF, 16'h0001);
    lat_arm = 1;
    send_frame(16'h0001, 1'b1, 16, 1'b1);
    check("lat_done", {31'd0, lat_arm}, 0);

    // Early EN drop after 9 bits
    ea++; eb++;
    send_frame(16'h0F0F, 1'b0, 9, 1'b1);
    push(16'h0000, 16'hFFFF);
    send_frame(16'hFFFF, 1'b0, 16, 1'b1);

    // Timeout after 5 bits
    ea++; eb++;
    tmo_ph = 1;
    send_frame(16'h5555, 1'b0, 5, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_busy_a", {31'd0, bz_a}, 0);
    check("tmo_busy_b", {31'd0, bz_b}, 0);
    s_en = 1'b0;
    tmo_ph = 0;
    repeat (8) @(negedge clk);

    // Clear mid-frame at bit 7
    send_frame(16'hFFFF, 1'b1, 7, 1'b0);
    s_clr = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_cnt", {26'd0, bc_a}, 0);
    check("clr_data_b", {16'd0, do_b}, 0);
    s_en = 1'b0;
    repeat (2) @(negedge clk);
    s_clr = 1'b1;
    repeat (6) @(negedge clk);
    check("clr_data_a", {16'd0, do_a}, 0);
    last_a = '0;
    last_b = '0;
    push(16'h3C5A, 16'hA5C3);
    send_frame(16'hC3A5, 1'b0, 16, 1'b1);

    // Back-to-back with EN held
    push(16'hEDCB, 16'h2C48);
    push(16'h5432, 16'hB3D5);
    send_frame(16'h1234, 1'b0, 16, 1'b0);
    repeat (4) @(negedge clk);
    send_frame(16'hABCD, 1'b0, 16, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && ea == 0 && eb == 0) break;
      @(negedge clk);
    end
    check("left_a", qa.size(), 0);
    check("left_b", qb.size(), 0);
    check("left_err", ea + eb, 0);
    check("end_cnt", {26'd0, bc_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_s2p_rx.md
Name: led_s2p_rx

Overview:
- Serial-to-parallel receiver for the LED shift-chain interface (LED_CLK / LED_CLR / LED_EN / LED_D0) that the panel LED driver transmits on.
- Reconstructs each WIDTH-bit frame into a parallel word with a one-cycle valid strobe.
- Used as a loopback monitor: the top level feeds the driver outputs back in to check displayed data, or the block listens to an external LED chain.
- Runs in the system clk domain; inputs are treated as asynchronous and synchronised.

Parameters:
- WIDTH, 16, bits per frame (2..32).
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first received bit lands in data_out[0].
- INVERT, 1, 1: data_out is the bitwise inverse of the line bits, because LEDs are active-low on the line.
- TIMEOUT, 4096, max clk cycles between s_clk rising edges inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- s_clk  in  1  serial shift clock (LED_CLK); data is sampled on its rising edge.
- s_d0  in  1  serial data (LED_D0).
- s_en  in  1  frame qualifier (LED_EN); high while a frame is shifting.
- s_clr  in  1  line clear (LED_CLR), active-low.
- data_out  out  WIDTH  last complete frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- busy  out  1  high in SHIFT.
- bit_cnt  out  6  bits received in the current frame.

Behaviour:
- Reset values while rst=0 at a clk edge: data_out=0, data_valid=0, frame_err=0, busy=0, bit_cnt=0, state=IDLE, shift register=0, timeout counter=0.
- Synchronisation:
  - s_clk, s_d0, s_en and s_clr each pass through a 2-FF synchroniser.
  - A rising-edge detect register on synced s_clk produces edge, 3 clk cycles after the pin rises.
  - s_d0 uses the same depth, so the sampled bit is aligned with edge.
  - Transmitter holds D0 stable at least 4 clk cycles around each rising edge of s_clk (guaranteed by the driver's divided clock).
- States:
  - IDLE:
    - edge with s_en_s=1 → shift in the bit, bit_cnt=1, go to SHIFT.
    - If WIDTH==1 the frame completes on that edge (parameter range forbids this).
    - edge with s_en_s=0 is ignored.
  - SHIFT, on each edge:
    - Shift in the bit and increment bit_cnt.
    - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit}.
    - MSB_FIRST=0: shreg <= {bit, shreg[WIDTH-1:1]}.
    - On the edge that makes bit_cnt==WIDTH → go to DONE.
  - DONE (exactly 1 cycle):
    - data_out <= INVERT ? ~shreg : shreg; data_valid=1 in this cycle.
    - bit_cnt <= 0; go to IDLE.
    - An edge arriving during DONE is held, not lost: it is processed as the first edge of the next frame.
  - ERR (exactly 1 cycle):
    - frame_err=1, data_out unchanged, bit_cnt <= 0, go to IDLE.
- Latency: data_valid is asserted 1 cycle after the clk cycle in which the WIDTH-th edge is detected, i.e. 4 cycles after the last s_clk pin rise.
- Aborts, all going SHIFT → ERR:
  - s_en_s falls while bit_cnt<WIDTH.
  - Timeout counter reaches TIMEOUT-1 with no edge. The counter resets on every edge and counts only in SHIFT.
- s_clr_s=0 has priority over everything except reset:
  - Forces IDLE, shreg=0, bit_cnt=0, data_out=0 in the same cycle.
  - No valid or err pulse is produced.
- Extra edges beyond WIDTH while s_en stays high start a new frame. The bench treats this as back-to-back frames.
- Simultaneous edge and s_en fall in SHIFT: the edge is counted first. If that completes the frame → DONE; otherwise → ERR.
- data_valid and frame_err are never high together.

Decomposition:
- Package led_ser_pkg:
  - state enum {IDLE, SHIFT, DONE, ERR} (2-bit).
  - SYNC_STAGES=2.
  - Bit-count width constant CNT_W=6.
- Sub-module sync_edge_det: a 2-FF synchroniser plus a rising-edge register. It is instantiated for s_clk (edge output used) and reused as plain sync for s_d0, s_en and s_clr.

Test Plan:
- Frame decode: rst pulse, then WIDTH=16, MSB_FIRST=1, INVERT=1; shift line bits of 16'h5A3C MSB first, 8-cycle s_clk period, s_en high → one data_valid pulse; data_out=16'hA5C3; bit_cnt returns to 0.
- LSB order: MSB_FIRST=0, INVERT=0; send 16'h0001 with bit0 first → data_out=16'h0001, valid 4 cycles after the 16th s_clk rise.
- Early s_en drop: drop s_en after 9 bits → frame_err pulse once; data_out keeps its previous value; next full frame 16'hFFFF decodes correctly.
- Timeout: stop s_clk after 5 bits for TIMEOUT+10 cycles → frame_err exactly TIMEOUT cycles after the last edge; busy falls.
- Clear mid-frame: assert s_clr low at bit 7 → data_out=0, no pulses; a subsequent frame decodes correctly.
- Back-to-back: two frames 16'h1234 and 16'hABCD with one s_clk period of gap, s_en held high → two valid pulses with matching data; no error.
